// File: rtl/axi_wr_stream_pkg.sv
// Shared constants for the AXI write-stream master: softreg map, AXI size code
// and the 4 KB page burst-length helper.
package axi_wr_stream_pkg;

    localparam logic [31:0] SR_WR_ADDR  = 32'h10;
    localparam logic [31:0] SR_CREDITS  = 32'h18;
    localparam logic [31:0] SR_WR_WORDS = 32'h20;
    localparam logic [31:0] SR_BEATS    = 32'h28;
    localparam logic [31:0] SR_BURSTS   = 32'h30;
    localparam logic [31:0] SR_ERRS     = 32'h38;

    localparam logic [2:0] AXI_SIZE_64B = 3'b110;
    localparam int         BEATS_PER_4K = 64;

    // Beats left in the transfer, clipped to the beats left in the current 4 KB page.
    function automatic logic [6:0] burst_len(input logic [63:0] words, input logic [63:0] addr);
        logic [6:0] room;
        room = 7'(BEATS_PER_4K) - {1'b0, addr[11:6]};
        if (words < {57'd0, room})
            return words[6:0];
        return room;
    endfunction

endpackage

// File: rtl/wr_burst_len_fifo.sv
// Burst-length queue: remembers the length of every accepted AW so the W side
// knows where each burst ends. Show-ahead head, synchronous reset.
module wr_burst_len_fifo #(
    parameter int LOG_DEPTH = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [6:0] push_data,
    input  logic       pop,
    output logic [6:0] head,
    output logic       full,
    output logic       empty
);

    localparam int DEPTH = 1 << LOG_DEPTH;

    logic [6:0]         mem [DEPTH];
    logic [LOG_DEPTH:0] wr_ptr;
    logic [LOG_DEPTH:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[LOG_DEPTH-1:0]] <= push_data;
    end

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[LOG_DEPTH] != rd_ptr[LOG_DEPTH]) &&
                   (wr_ptr[LOG_DEPTH-1:0] == rd_ptr[LOG_DEPTH-1:0]);
    assign head  = mem[rd_ptr[LOG_DEPTH-1:0]];

endmodule

// File: rtl/axi_wr_stream.sv
// AXI4 write master: drains a 512-bit stream into memory as bursts that never
// cross a 4 KB page, throttled by a credit counter replenished by B responses.
module axi_wr_stream
    import axi_wr_stream_pkg::*;
#(
    parameter int LOG_BQ_DEPTH = 3,
    parameter int CREDIT_W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    output logic [15:0]  awid_m,
    output logic [63:0]  awaddr_m,
    output logic [7:0]   awlen_m,
    output logic [2:0]   awsize_m,
    output logic         awvalid_m,
    input  logic         awready_m,
    output logic [511:0] wdata_m,
    output logic [63:0]  wstrb_m,
    output logic         wlast_m,
    output logic         wvalid_m,
    input  logic         wready_m,
    input  logic [15:0]  bid_m,
    input  logic [1:0]   bresp_m,
    input  logic         bvalid_m,
    output logic         bready_m,
    input  logic         in_valid,
    input  logic [511:0] in_data,
    output logic         in_ready,
    input  logic         softreg_req_valid,
    input  logic         softreg_req_isWrite,
    input  logic [31:0]  softreg_req_addr,
    input  logic [63:0]  softreg_req_data,
    output logic         softreg_resp_valid,
    output logic [63:0]  softreg_resp_data
);

    logic [63:0]         wr_addr;
    logic [63:0]         wr_words;
    logic [63:0]         beats_written;
    logic [63:0]         bursts_done;
    logic [63:0]         err_cnt;
    logic [CREDIT_W-1:0] credits;
    logic [6:0]          beat_cnt;
    logic [6:0]          len;
    logic [6:0]          head_len;
    logic                q_full;
    logic                q_empty;
    logic                aw_hs;
    logic                w_hs;
    logic                w_last_hs;
    logic                b_hs;
    logic                sr_wr;
    logic                sr_rd;
    logic                unused_bits;

    assign unused_bits = ^{bid_m, softreg_req_data[63:CREDIT_W]};

    assign sr_wr = softreg_req_valid && softreg_req_isWrite;
    assign sr_rd = softreg_req_valid && !softreg_req_isWrite;

    assign len       = burst_len(wr_words, wr_addr);
    assign awid_m    = '0;
    assign awaddr_m  = wr_addr;
    assign awlen_m   = {1'b0, len - 7'd1};
    assign awsize_m  = AXI_SIZE_64B;
    assign awvalid_m = (wr_words != '0) && (credits != '0) && !q_full;
    assign aw_hs     = awvalid_m && awready_m;

    // W is gated on a queued burst, so data can never run ahead of its AW.
    assign wdata_m   = in_data;
    assign wstrb_m   = '1;
    assign wvalid_m  = in_valid && !q_empty;
    assign in_ready  = wready_m && !q_empty;
    assign wlast_m   = (beat_cnt == head_len - 7'd1);
    assign w_hs      = wvalid_m && wready_m;
    assign w_last_hs = w_hs && wlast_m;

    assign bready_m  = 1'b1;
    assign b_hs      = bvalid_m;

    wr_burst_len_fifo #(
        .LOG_DEPTH (LOG_BQ_DEPTH)
    ) u_len_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (aw_hs),
        .push_data (len),
        .pop       (w_last_hs),
        .head      (head_len),
        .full      (q_full),
        .empty     (q_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_addr  <= '0;
            wr_words <= '0;
            credits  <= CREDIT_W'(8);
        end else begin
            if (sr_wr && softreg_req_addr == SR_WR_ADDR)
                wr_addr <= softreg_req_data;
            else if (aw_hs)
                wr_addr <= wr_addr + {51'd0, len, 6'd0};

            if (sr_wr && softreg_req_addr == SR_WR_WORDS)
                wr_words <= softreg_req_data;
            else if (aw_hs)
                wr_words <= wr_words - {57'd0, len};

            // A simultaneous AW and B cancel out.
            if (sr_wr && softreg_req_addr == SR_CREDITS)
                credits <= softreg_req_data[CREDIT_W-1:0];
            else if (aw_hs && !b_hs)
                credits <= credits - 1'b1;
            else if (b_hs && !aw_hs)
                credits <= credits + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt <= '0;
        end else if (w_last_hs) begin
            beat_cnt <= '0;
        end else if (w_hs) begin
            beat_cnt <= beat_cnt + 7'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beats_written <= '0;
            bursts_done   <= '0;
            err_cnt       <= '0;
        end else if (sr_wr && softreg_req_addr == SR_WR_WORDS) begin
            beats_written <= '0;
            bursts_done   <= '0;
            err_cnt       <= '0;
        end else begin
            if (w_hs)
                beats_written <= beats_written + 64'd1;
            if (b_hs)
                bursts_done <= bursts_done + 64'd1;
            if (b_hs && bresp_m != 2'b00)
                err_cnt <= err_cnt + 64'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            softreg_resp_valid <= 1'b0;
            softreg_resp_data  <= '0;
        end else begin
            softreg_resp_valid <= sr_rd;
            softreg_resp_data  <= '0;
            if (sr_rd) begin
                case (softreg_req_addr)
                    SR_BEATS:  softreg_resp_data <= beats_written;
                    SR_BURSTS: softreg_resp_data <= bursts_done;
                    SR_ERRS:   softreg_resp_data <= err_cnt;
                    default:   softreg_resp_data <= '0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_axi_wr_stream.sv
// Directed bench for axi_wr_stream: a stream source, an AXI slave model that
// records AW/W/B traffic, and hand-computed expectations per scenario.
module tb_axi_wr_stream;
    import axi_wr_stream_pkg::*;

    logic         clk;
    logic         rst;
    logic [15:0]  awid_m;
    logic [63:0]  awaddr_m;
    logic [7:0]   awlen_m;
    logic [2:0]   awsize_m;
    logic         awvalid_m;
    logic         awready_m;
    logic [511:0] wdata_m;
    logic [63:0]  wstrb_m;
    logic         wlast_m;
    logic         wvalid_m;
    logic         wready_m;
    logic [15:0]  bid_m;
    logic [1:0]   bresp_m;
    logic         bvalid_m;
    logic         bready_m;
    logic         in_valid;
    logic [511:0] in_data;
    logic         in_ready;
    logic         softreg_req_valid;
    logic         softreg_req_isWrite;
    logic [31:0]  softreg_req_addr;
    logic [63:0]  softreg_req_data;
    logic         softreg_resp_valid;
    logic [63:0]  softreg_resp_data;

    axi_wr_stream #(
        .LOG_BQ_DEPTH (3),
        .CREDIT_W     (8)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .awid_m              (awid_m),
        .awaddr_m            (awaddr_m),
        .awlen_m             (awlen_m),
        .awsize_m            (awsize_m),
        .awvalid_m           (awvalid_m),
        .awready_m           (awready_m),
        .wdata_m             (wdata_m),
        .wstrb_m             (wstrb_m),
        .wlast_m             (wlast_m),
        .wvalid_m            (wvalid_m),
        .wready_m            (wready_m),
        .bid_m               (bid_m),
        .bresp_m             (bresp_m),
        .bvalid_m            (bvalid_m),
        .bready_m            (bready_m),
        .in_valid            (in_valid),
        .in_data             (in_data),
        .in_ready            (in_ready),
        .softreg_req_valid   (softreg_req_valid),
        .softreg_req_isWrite (softreg_req_isWrite),
        .softreg_req_addr    (softreg_req_addr),
        .softreg_req_data    (softreg_req_data),
        .softreg_resp_valid  (softreg_resp_valid),
        .softreg_resp_data   (softreg_resp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    // Source / sink / B-responder controls (written only by the main initial block)
    int src_total = 0;
    int gap_mode  = 0;   // 0 free-flowing, 1 random gaps, 2 W stalled
    bit b_hold    = 1'b0;
    int err_idx   = -1;

    // Observed traffic (written only by the monitor)
    int cyc = 0;
    int src_idx = 0;
    int aw_n = 0, w_n = 0, wl_n = 0, b_sent = 0, pending_b = 0, order_err = 0;
    logic [63:0] aw_addr [64];
    int          aw_len  [64];
    int          aw_cyc  [64];
    int          b_cyc   [64];
    logic        wl      [2048];
    logic [63:0] wd_lo   [2048];
    logic [63:0] wd_hi   [2048];

    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (src_idx < src_total)
            in_valid = (gap_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        else
            in_valid = 1'b0;
        in_data  = {8{64'(src_idx)}};
        wready_m = (gap_mode == 0) ? 1'b1 : (gap_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        bvalid_m = (pending_b > 0) && !b_hold;
        bresp_m  = (b_sent == err_idx) ? 2'b10 : 2'b00;
    end

    // Inputs are stable at the falling edge, so valid&&ready here is the next rising-edge handshake.
    always @(negedge clk) begin
        if (rst) begin
            pending_b = 0;
            wl_n = aw_n;
        end else begin
            if (wvalid_m && !(wl_n < aw_n))
                order_err = order_err + 1;
            if (awvalid_m && awready_m) begin
                aw_addr[aw_n] = awaddr_m;
                aw_len[aw_n]  = int'(awlen_m);
                aw_cyc[aw_n]  = cyc;
                aw_n = aw_n + 1;
            end
            if (in_valid && in_ready)
                src_idx = src_idx + 1;
            if (wvalid_m && wready_m) begin
                wd_lo[w_n] = wdata_m[63:0];
                wd_hi[w_n] = wdata_m[511:448];
                wl[w_n]    = wlast_m;
                w_n = w_n + 1;
                if (wlast_m) begin
                    wl_n = wl_n + 1;
                    pending_b = pending_b + 1;
                end
            end
            if (bvalid_m) begin
                b_cyc[b_sent] = cyc;
                b_sent = b_sent + 1;
                pending_b = pending_b - 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk = n_chk + 1;
        if (obs === exp)
            n_pass = n_pass + 1;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic sr_wr(input logic [31:0] addr, input logic [63:0] data);
        @(posedge clk); #2;
        softreg_req_valid   = 1'b1;
        softreg_req_isWrite = 1'b1;
        softreg_req_addr    = addr;
        softreg_req_data    = data;
        @(posedge clk); #2;
        softreg_req_valid   = 1'b0;
        softreg_req_isWrite = 1'b0;
    endtask

    task automatic sr_rd(input string tag, input logic [31:0] addr, input logic [63:0] exp);
        @(posedge clk); #2;
        softreg_req_valid   = 1'b1;
        softreg_req_isWrite = 1'b0;
        softreg_req_addr    = addr;
        @(posedge clk); #2;
        softreg_req_valid   = 1'b0;
        chk({tag, " resp_valid"}, 64'(softreg_resp_valid), 64'd1);
        chk(tag, softreg_resp_data, exp);
    endtask

    task automatic wait_b(input string tag, input int target, input int budget);
        int n;
        n = 0;
        while (b_sent < target && n < budget) begin
            @(posedge clk);
            n = n + 1;
        end
        #2;
        chk({tag, " completed in budget"}, 64'(b_sent >= target), 64'd1);
    endtask

    task automatic chk_aw(input string tag, input int idx, input logic [63:0] addr, input int len);
        chk({tag, " awaddr"}, aw_addr[idx], addr);
        chk({tag, " awlen"}, 64'(aw_len[idx]), 64'(len));
    endtask

    task automatic chk_data(input string tag, input int first, input int n);
        int errs;
        errs = 0;
        for (int i = first; i < first + n; i++)
            if (wd_lo[i] !== 64'(i) || wd_hi[i] !== 64'(i))
                errs = errs + 1;
        chk({tag, " data order errors"}, 64'(errs), 64'd0);
    endtask

    task automatic start(input logic [63:0] addr, input int words);
        src_total = src_idx + words;
        sr_wr(SR_WR_ADDR, addr);
        sr_wr(SR_WR_WORDS, 64'(words));
    endtask

    int a0, w0, b0, n, wl_cnt;
    logic [3:0] pat;

    initial begin
        rst = 1'b1;
        awready_m = 1'b1;
        bid_m = 16'h0;
        bresp_m = 2'b00;
        bvalid_m = 1'b0;
        wready_m = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        softreg_req_valid = 1'b0;
        softreg_req_isWrite = 1'b0;
        softreg_req_addr = '0;
        softreg_req_data = '0;
        tick(3);

        // Reset state
        chk("rst awvalid", 64'(awvalid_m), 64'd0);
        chk("rst wvalid", 64'(wvalid_m), 64'd0);
        chk("rst in_ready", 64'(in_ready), 64'd0);
        chk("rst resp_valid", 64'(softreg_resp_valid), 64'd0);
        chk("rst resp_data", softreg_resp_data, 64'd0);
        chk("awsize", 64'(awsize_m), 64'd6);
        chk("wstrb", wstrb_m, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("bready", 64'(bready_m), 64'd1);
        chk("awid", 64'(awid_m), 64'd0);
        rst = 1'b0;
        sr_rd("rst beats", SR_BEATS, 64'd0);
        sr_rd("unmapped addr", 32'h40, 64'd0);

        // 1: single 4-beat burst
        a0 = aw_n; w0 = w_n; b0 = b_sent;
        start(64'h0, 4);
        wait_b("t1", b0 + 1, 200);
        chk("t1 aw count", 64'(aw_n - a0), 64'd1);
        chk_aw("t1", a0, 64'h0, 3);
        for (int i = 0; i < 4; i++) pat[i] = wl[w0 + i];
        chk("t1 wlast pattern", 64'(pat), 64'h8);
        chk_data("t1", w0, 4);
        sr_rd("t1 beats", SR_BEATS, 64'd4);
        chk("t1 resp pulse", 64'(softreg_resp_valid), 64'd1);
        tick(1);
        chk("t1 resp pulse drop", 64'(softreg_resp_valid), 64'd0);
        sr_rd("t1 bursts", SR_BURSTS, 64'd1);
        sr_rd("t1 errs", SR_ERRS, 64'd0);

        // 2: 4 KB split, single-beat burst
        a0 = aw_n; w0 = w_n; b0 = b_sent;
        start(64'hFC0, 3);
        wait_b("t2", b0 + 2, 200);
        chk("t2 aw count", 64'(aw_n - a0), 64'd2);
        chk_aw("t2a", a0, 64'hFC0, 0);
        chk_aw("t2b", a0 + 1, 64'h1000, 1);
        pat = '0;
        for (int i = 0; i < 3; i++) pat[i] = wl[w0 + i];
        chk("t2 wlast pattern", 64'(pat), 64'h5);
        sr_rd("t2 beats", SR_BEATS, 64'd3);

        // 3: one credit, B held off
        a0 = aw_n; w0 = w_n; b0 = b_sent;
        sr_wr(SR_CREDITS, 64'd1);
        b_hold = 1'b1;
        start(64'h0, 128);
        tick(120);
        chk("t3 aw count held", 64'(aw_n - a0), 64'd1);
        chk_aw("t3a", a0, 64'h0, 63);
        chk("t3 beats before B", 64'(w_n - w0), 64'd64);
        b_hold = 1'b0;
        wait_b("t3", b0 + 2, 400);
        chk("t3 aw count", 64'(aw_n - a0), 64'd2);
        chk_aw("t3b", a0 + 1, 64'h1000, 63);
        chk("t3 AW one cycle after B", 64'(aw_cyc[a0 + 1] - b_cyc[b0]), 64'd1);
        sr_wr(SR_CREDITS, 64'd8);

        // 4: random gaps on both sides
        a0 = aw_n; w0 = w_n; b0 = b_sent;
        gap_mode = 1;
        start(64'h0, 70);
        wait_b("t4", b0 + 2, 2000);
        gap_mode = 0;
        chk("t4 aw count", 64'(aw_n - a0), 64'd2);
        chk_aw("t4a", a0, 64'h0, 63);
        chk_aw("t4b", a0 + 1, 64'h1000, 5);
        chk_data("t4", w0, 70);
        wl_cnt = 0;
        for (int i = 0; i < 70; i++) if (wl[w0 + i]) wl_cnt = wl_cnt + 1;
        chk("t4 wlast count", 64'(wl_cnt), 64'd2);
        chk("t4 wlast beat 64", 64'(wl[w0 + 63]), 64'd1);
        chk("t4 wlast beat 70", 64'(wl[w0 + 69]), 64'd1);

        // 5: error response on the second of two bursts
        b0 = b_sent;
        err_idx = b0 + 1;
        start(64'hFC0, 2);
        wait_b("t5", b0 + 2, 200);
        err_idx = -1;
        sr_rd("t5 errs", SR_ERRS, 64'd1);
        sr_rd("t5 bursts", SR_BURSTS, 64'd2);
        sr_rd("t5 beats", SR_BEATS, 64'd2);

        // Queue full holds AW even with spare credits
        a0 = aw_n; w0 = w_n; b0 = b_sent;
        gap_mode = 2;
        sr_wr(SR_CREDITS, 64'd16);
        start(64'h0, 640);
        tick(30);
        chk("qfull aw count", 64'(aw_n - a0), 64'd8);
        gap_mode = 0;
        wait_b("qfull", b0 + 10, 1500);
        chk("qfull aw total", 64'(aw_n - a0), 64'd10);
        chk_aw("qfull last", a0 + 9, 64'h9000, 63);
        chk_data("qfull", w0, 640);
        sr_wr(SR_CREDITS, 64'd8);
        sr_rd("qfull bursts", SR_BURSTS, 64'd10);

        // 6: reset mid-burst, then a clean 2-beat transfer
        w0 = w_n;
        start(64'h0, 64);
        n = 0;
        while (w_n < w0 + 10 && n < 200) begin
            @(posedge clk);
            n = n + 1;
        end
        #2;
        chk("t6 reached beat 10", 64'(w_n >= w0 + 10), 64'd1);
        rst = 1'b1;
        tick(1);
        chk("t6 awvalid after rst", 64'(awvalid_m), 64'd0);
        chk("t6 wvalid after rst", 64'(wvalid_m), 64'd0);
        chk("t6 in_ready after rst", 64'(in_ready), 64'd0);
        rst = 1'b0;
        sr_rd("t6 beats after rst", SR_BEATS, 64'd0);
        a0 = aw_n; w0 = w_n; b0 = b_sent;
        src_total = src_idx + 2;
        sr_wr(SR_WR_ADDR, 64'h0);
        sr_wr(SR_WR_WORDS, 64'd2);
        wait_b("t6", b0 + 1, 200);
        chk("t6 aw count", 64'(aw_n - a0), 64'd1);
        chk_aw("t6", a0, 64'h0, 1);
        pat = '0;
        for (int i = 0; i < 2; i++) pat[i] = wl[w0 + i];
        chk("t6 wlast pattern", 64'(pat), 64'h2);
        chk_data("t6", w0, 2);
        sr_rd("t6 beats", SR_BEATS, 64'd2);
        sr_rd("t6 bursts", SR_BURSTS, 64'd1);

        src_total = src_idx;
        tick(2);
        chk("W never led AW", 64'(order_err), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
